// File: rtl/queue_serial_reader.sv
// queue_serial_reader
// Pops words from the FIFO queue read port and shifts each one out on a
// single asynchronous serial line: start bit, DATA_WIDTH data bits LSB
// first, optional even-parity bit, stop bit.
// Optional feature macro: PARITY_EN (adds the even-parity bit and state).
module queue_serial_reader #(
    parameter int DATA_WIDTH   = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_cmd,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done_tick
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W  = $clog2(DATA_WIDTH) + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] REQ    = 3'd1;
    localparam logic [2:0] LOAD   = 3'd2;
    localparam logic [2:0] START  = 3'd3;
    localparam logic [2:0] DATA   = 3'd4;
`ifdef PARITY_EN
    localparam logic [2:0] PARITY = 3'd5;
`endif
    localparam logic [2:0] STOP   = 3'd6;

    logic [2:0]            state;
    logic [BAUD_W-1:0]     baud;
    logic [IDX_W-1:0]      bit_idx;
    logic [DATA_WIDTH-1:0] shift;
    logic [DATA_WIDTH-1:0] shift_next;
    logic                  baud_end;
`ifdef PARITY_EN
    logic                  parity;
`endif

    // Next shift value and end-of-bit-period detect
    always_comb begin
        shift_next = shift >> 1;
        baud_end   = (baud == BAUD_LAST);
    end

    // Frame sequencer: pop request, load, then start/data/parity/stop timing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            baud         <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            tx           <= 1'b1;
            read_cmd     <= 1'b0;
            busy         <= 1'b0;
            tx_done_tick <= 1'b0;
`ifdef PARITY_EN
            parity       <= 1'b0;
`endif
        end else begin
            tx_done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (!empty) begin
                        read_cmd <= 1'b1;
                        busy     <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    read_cmd <= 1'b0;
                    state    <= LOAD;
                end
                LOAD: begin
                    shift <= read_data;
`ifdef PARITY_EN
                    parity <= ^read_data;
`endif
                    tx    <= 1'b0;
                    baud  <= '0;
                    state <= START;
                end
                START: begin
                    if (baud_end) begin
                        baud    <= '0;
                        tx      <= shift[0];
                        bit_idx <= '0;
                        state   <= DATA;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud  <= '0;
                        shift <= shift_next;
                        if (bit_idx == IDX_LAST) begin
`ifdef PARITY_EN
                            tx    <= parity;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            tx      <= shift_next[0];
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
`ifdef PARITY_EN
                PARITY: begin
                    if (baud_end) begin
                        baud  <= '0;
                        tx    <= 1'b1;
                        state <= STOP;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (baud_end) begin
                        baud         <= '0;
                        tx_done_tick <= 1'b1;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: begin
                    tx       <= 1'b1;
                    read_cmd <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_queue_serial_reader.sv
// tb_queue_serial_reader
// Drives queue_serial_reader (DATA_WIDTH=4, CLKS_PER_BIT=4) from a
// behavioural queue. Expected line levels are pushed to a scoreboard when a
// word is offered and compared as the serial line produces them.
// Honours PARITY_EN in the same way as the design.
module tb_queue_serial_reader;

    localparam int DW  = 4;
    localparam int CPB = 4;
`ifdef PARITY_EN
    localparam int LEVELS    = DW + 3;
    localparam int FRAME_CYC = 28;
`else
    localparam int LEVELS    = DW + 2;
    localparam int FRAME_CYC = 24;
`endif

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          empty     = 1'b1;
    logic [DW-1:0] read_data = '0;
    logic          read_cmd;
    logic          tx;
    logic          busy;
    logic          tx_done_tick;

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] fifo[$];
    logic          exp_q[$];
    int            pop_count  = 0;
    int            done_count = 0;
    int            overpop    = 0;

    queue_serial_reader #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .empty       (empty),
        .read_data   (read_data),
        .read_cmd    (read_cmd),
        .tx          (tx),
        .busy        (busy),
        .tx_done_tick(tx_done_tick)
    );

    always #5 clk = ~clk;

    // Behavioural queue: pops on sampled read_cmd, registered empty flag
    always @(posedge clk) begin
        if (read_cmd) begin
            pop_count <= pop_count + 1;
            if (fifo.size() == 0) overpop <= overpop + 1;
            else read_data <= fifo.pop_front();
        end
        if (tx_done_tick) done_count <= done_count + 1;
        empty <= (fifo.size() == 0);
    end

    // Offer a word to the queue and record the line levels it must produce
    task automatic push_word(input logic [DW-1:0] w);
        fifo.push_back(w);
        exp_q.push_back(1'b0);
        for (int i = 0; i < DW; i++) exp_q.push_back(w[i]);
`ifdef PARITY_EN
        exp_q.push_back(^w);
`endif
        exp_q.push_back(1'b1);
    endtask

    // Wait for a start bit and compare every cycle of the frame
    task automatic check_frame(input string name);
        int   waited = 0;
        logic b;
        while (tx !== 1'b0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        vectors++;
        if (tx !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_start_timeout: tx=%b required 0", name, tx);
            return;
        end
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_busy_in_frame: busy=%b required 1", name, busy);
        end
        for (int l = 0; l < LEVELS; l++) begin
            b = exp_q.pop_front();
            for (int c = 0; c < CPB; c++) begin
                vectors++;
                if (tx !== b || tx_done_tick !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s_level%0d_cyc%0d: tx=%b done=%b required tx=%b done=0",
                             name, l, c, tx, tx_done_tick, b);
                end
                @(negedge clk);
            end
        end
        vectors++;
        if (tx_done_tick !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_done_tick: tx_done_tick=%b required 1", name, tx_done_tick);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_busy_after: busy=%b required 0", name, busy);
        end
    endtask

    task automatic test_reset();
        fifo.push_back(4'b1011);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vectors++;
            if ({tx, read_cmd, busy, tx_done_tick} !== 4'b1000) begin
                miscompares++;
                $display("FAIL reset_hold: tx,read_cmd,busy,done=%b required 1000",
                         {tx, read_cmd, busy, tx_done_tick});
            end
        end
        vectors++;
        if (pop_count !== 0) begin
            miscompares++;
            $display("FAIL reset_no_pop: pops=%0d required 0", pop_count);
        end
        fifo.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int p0 = pop_count;
        int d0 = done_count;
        int waited = 0;
        push_word(4'b1011);
        while (read_cmd !== 1'b1 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        vectors++;
        if (read_cmd !== 1'b1) begin
            miscompares++;
            $display("FAIL single_read_cmd: read_cmd=%b required 1", read_cmd);
        end
        @(negedge clk);
        vectors++;
        if (read_cmd !== 1'b0 || tx !== 1'b1) begin
            miscompares++;
            $display("FAIL single_req_cycle: read_cmd=%b tx=%b required read_cmd=0 tx=1",
                     read_cmd, tx);
        end
        @(negedge clk);
        vectors++;
        if (tx !== 1'b0) begin
            miscompares++;
            $display("FAIL single_tx_fall_k2: tx=%b required 0", tx);
        end
        check_frame("single");
        repeat (4) @(negedge clk);
        vectors++;
        if (pop_count !== p0 + 1 || done_count !== d0 + 1) begin
            miscompares++;
            $display("FAIL single_counts: pops=%0d done=%0d required pops=%0d done=%0d",
                     pop_count - p0, done_count - d0, 1, 1);
        end
    endtask

    task automatic test_back_to_back();
        int p0 = pop_count;
        int d0 = done_count;
        push_word(4'hA);
        push_word(4'h5);
        check_frame("b2b_first");
        for (int g = 0; g < 3; g++) begin
            vectors++;
            if (tx !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_gap%0d: tx=%b required 1", g, tx);
            end
            @(negedge clk);
        end
        vectors++;
        if (tx !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_gap_end: tx=%b required 0", tx);
        end
        check_frame("b2b_second");
        repeat (4) @(negedge clk);
        vectors++;
        if (pop_count !== p0 + 2 || done_count !== d0 + 2) begin
            miscompares++;
            $display("FAIL b2b_counts: pops=%0d done=%0d required pops=2 done=2",
                     pop_count - p0, done_count - d0);
        end
    endtask

    task automatic test_empty_hold();
        int p0 = pop_count;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            vectors++;
            if ({read_cmd, tx, busy} !== 3'b010) begin
                miscompares++;
                $display("FAIL empty_hold: read_cmd,tx,busy=%b required 010",
                         {read_cmd, tx, busy});
            end
        end
        vectors++;
        if (pop_count !== p0) begin
            miscompares++;
            $display("FAIL empty_no_pop: pops=%0d required 0", pop_count - p0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int   p0 = pop_count;
        int   d0 = done_count;
        int   waited = 0;
        logic b;
        push_word(4'hF);
        while (tx !== 1'b0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        vectors++;
        if (tx !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_start_timeout: tx=%b required 0", tx);
        end
        for (int l = 0; l < 3; l++) begin
            b = exp_q.pop_front();
            for (int c = 0; c < CPB; c++) begin
                vectors++;
                if (tx !== b) begin
                    miscompares++;
                    $display("FAIL mid_level%0d_cyc%0d: tx=%b required %b", l, c, tx, b);
                end
                @(negedge clk);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++;
        if ({tx, read_cmd, busy, tx_done_tick} !== 4'b1000) begin
            miscompares++;
            $display("FAIL mid_reset_immediate: tx,read_cmd,busy,done=%b required 1000",
                     {tx, read_cmd, busy, tx_done_tick});
        end
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            vectors++;
            if ({read_cmd, tx, busy, tx_done_tick} !== 4'b0100) begin
                miscompares++;
                $display("FAIL mid_after_release: read_cmd,tx,busy,done=%b required 0100",
                         {read_cmd, tx, busy, tx_done_tick});
            end
        end
        vectors++;
        if (done_count !== d0 || pop_count !== p0 + 1) begin
            miscompares++;
            $display("FAIL mid_counts: done=%0d pops=%0d required done=0 pops=1",
                     done_count - d0, pop_count - p0);
        end
    endtask

    task automatic test_parity_word();
        push_word(4'b0111);
        check_frame("word0111");
        repeat (3) @(negedge clk);
    endtask

    task automatic test_frame_length();
        int waited = 0;
        int cyc    = 0;
        fifo.push_back(4'b0111);
        while (tx !== 1'b0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        while (tx_done_tick !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (cyc !== FRAME_CYC) begin
            miscompares++;
            $display("FAIL frame_length: cycles=%0d required %0d", cyc, FRAME_CYC);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_no_overpop();
        vectors++;
        if (overpop !== 0) begin
            miscompares++;
            $display("FAIL over_pop: pops_while_empty=%0d required 0", overpop);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_empty_hold();
        test_reset_mid_frame();
        test_parity_word();
        test_frame_length();
        test_no_overpop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
